// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Host FSM encoding and starvation counter sizing.
package dmem_arbiter_pkg;

  typedef enum logic {
    H_IDLE = 1'b0,
    H_ACK  = 1'b1
  } host_state_e;

  localparam int STARVE_LIM_DEF = 4;

  function automatic int cnt_w(input int lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/dmem_starve_counter.sv
// Saturating count of cycles a pending host request lost to the core.
// at_limit forces the next host grant.
module dmem_starve_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int LIM = STARVE_LIM_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int W = cnt_w(LIM);
  localparam logic [W-1:0] LIM_V = W'(LIM);

  logic [W-1:0] cnt;

  assign at_limit = (cnt == LIM_V);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/host arbiter for the single-port data memory.
// Core has priority; starvation counter bounds host wait.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic HOST_FIRST = (STARVE_LIM == 0);

  host_state_e state;
  logic        host_elig;
  logic        host_grant;
  logic        core_grant;
  logic        at_limit;
  logic        mux_we;

  assign host_elig  = (state == H_IDLE) & host_req;
  assign host_grant = host_elig
                    & (~cpu_req | at_limit | HOST_FIRST);
  assign core_grant = cpu_req & ~host_grant;

  dmem_starve_counter #(
    .LIM (STARVE_LIM)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (host_elig & ~host_grant),
    .clr      (host_grant | ~host_req),
    .at_limit (at_limit)
  );

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mux_we    = cpu_we & core_grant;
    unique case (1'b1)
      host_grant: begin
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        mux_we    = host_we;
      end
      default: ;
    endcase
  end

  // Both strobes are held low while in reset.
  assign mem_we    = reset & mux_we;
  assign cpu_stall = reset & cpu_req & ~core_grant;
  assign cpu_rdata = mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= H_IDLE;
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      unique case (state)
        H_IDLE: begin
          if (host_grant) begin
            state      <= H_ACK;
            host_ack   <= 1'b1;
            host_rdata <= mem_rdata;
          end
        end
        H_ACK: begin
          state    <= H_IDLE;
          host_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model, STARVE_LIM 4 and 0.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_clr;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        host_req, host_we;
  logic [15:0] host_addr, host_wdata;

  logic        mem_we4, stall4, ack4;
  logic [15:0] mem_addr4, mem_wdata4, cpu_rdata4, hrd4, mem_rdata4;
  logic        mem_we0, stall0, ack0;
  logic [15:0] mem_addr0, mem_wdata0, cpu_rdata0, hrd0, mem_rdata0;

  logic [15:0] mem4 [0:255];
  logic [15:0] mem0 [0:255];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIM(4)) u4 (
    .clk(clk), .reset(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata4), .cpu_stall(stall4),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(hrd4), .host_ack(ack4),
    .mem_we(mem_we4), .mem_addr(mem_addr4),
    .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4)
  );

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIM(0)) u0 (
    .clk(clk), .reset(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata0), .cpu_stall(stall0),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(hrd0), .host_ack(ack0),
    .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
  );

  assign mem_rdata4 = mem4[mem_addr4[7:0]];
  assign mem_rdata0 = mem0[mem_addr0[7:0]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem4[i] <= '0;
    end else if (mem_we4) begin
      mem4[mem_addr4[7:0]] <= mem_wdata4;
    end
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem0[i] <= '0;
    end else if (mem_we0) begin
      mem0[mem_addr0[7:0]] <= mem_wdata0;
    end
  end

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0;
    cpu_addr = 0; cpu_wdata = 0;
    host_req = 0; host_we = 0;
    host_addr = 0; host_wdata = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0; mem_clr = 1;
    cpu_req = 1; cpu_we = 1;
    cpu_addr = 16'h0010; cpu_wdata = 16'hdead;
    host_req = 1; host_we = 1;
    host_addr = 16'h0020; host_wdata = 16'hdead;
    #2;
    total++;
    if (mem_we4 !== 1'b0) begin
      bad++; $display("FAIL rst_mem_we got %b want 0", mem_we4);
    end
    total++;
    if (stall4 !== 1'b0) begin
      bad++; $display("FAIL rst_stall got %b want 0", stall4);
    end
    total++;
    if (ack4 !== 1'b0) begin
      bad++; $display("FAIL rst_ack got %b want 0", ack4);
    end
    total++;
    if (hrd4 !== 16'h0000) begin
      bad++; $display("FAIL rst_hrd got %h want 0000", hrd4);
    end
    total++;
    if ({mem_we0, stall0} !== 2'b00) begin
      bad++;
      $display("FAIL rst_l0 got %b%b want 00", mem_we0, stall0);
    end
    @(negedge clk);
    mem_clr = 0;
    #2;
    total++;
    if ({mem_we4, stall4, ack4} !== 3'b000) begin
      bad++;
      $display("FAIL rst_hold got %b%b%b want 000",
               mem_we4, stall4, ack4);
    end
    @(negedge clk);
    rst_n = 1;
    idle_inputs();
  endtask

  task automatic test_core_only();
    @(negedge clk);
    cpu_req = 1; cpu_we = 1;
    cpu_addr = 16'h0010; cpu_wdata = 16'hbeef;
    #2;
    total++;
    if ({mem_we4, stall4} !== 2'b10) begin
      bad++;
      $display("FAIL core_wr got we=%b stall=%b want 1,0",
               mem_we4, stall4);
    end
    total++;
    if ({mem_addr4, mem_wdata4} !== {16'h0010, 16'hbeef}) begin
      bad++;
      $display("FAIL core_wr_bus got %h/%h want 0010/beef",
               mem_addr4, mem_wdata4);
    end
    @(negedge clk);
    cpu_we = 0;
    #2;
    total++;
    if (cpu_rdata4 !== 16'hbeef || stall4 !== 1'b0) begin
      bad++;
      $display("FAIL core_rd got %h stall=%b want beef,0",
               cpu_rdata4, stall4);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_host_only();
    @(negedge clk);
    cpu_addr = 16'h0005;
    host_req = 1; host_we = 1;
    host_addr = 16'h0020; host_wdata = 16'h1234;
    #2;
    total++;
    if ({mem_we4, mem_addr4, ack4} !== {1'b1, 16'h0020, 1'b0}) begin
      bad++;
      $display("FAIL host_wr got we=%b a=%h ack=%b want 1,0020,0",
               mem_we4, mem_addr4, ack4);
    end
    @(negedge clk);
    host_we = 0;
    #2;
    total++;
    if (ack4 !== 1'b1) begin
      bad++; $display("FAIL host_wr_ack got %b want 1", ack4);
    end
    total++;
    if ({mem_we4, mem_addr4} !== {1'b0, 16'h0005}) begin
      bad++;
      $display("FAIL ack_no_grant got we=%b a=%h want 0,0005",
               mem_we4, mem_addr4);
    end
    @(negedge clk);
    #2;
    total++;
    if ({ack4, mem_addr4} !== {1'b0, 16'h0020}) begin
      bad++;
      $display("FAIL host_rd_grant got ack=%b a=%h want 0,0020",
               ack4, mem_addr4);
    end
    @(negedge clk);
    host_req = 0;
    #2;
    total++;
    if ({ack4, hrd4} !== {1'b1, 16'h1234}) begin
      bad++;
      $display("FAIL host_rd got ack=%b d=%h want 1,1234",
               ack4, hrd4);
    end
    @(negedge clk);
    #2;
    total++;
    if ({ack4, hrd4} !== {1'b0, 16'h1234}) begin
      bad++;
      $display("FAIL ack_pulse got ack=%b d=%h want 0,1234",
               ack4, hrd4);
    end
    idle_inputs();
  endtask

  task automatic test_contention();
    logic        e_stall, e_ack;
    logic [15:0] e_addr;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0001;
        host_req = 1; host_we = 0; host_addr = 16'h0020;
      end
      if (i == 5) host_req = 0;
      #2;
      e_stall = (i == 4);
      e_ack   = (i == 5);
      e_addr  = (i == 4) ? 16'h0020 : 16'h0001;
      total++;
      if ({stall4, ack4, mem_addr4} !== {e_stall, e_ack, e_addr}) begin
        bad++;
        $display("FAIL contend_c%0d got s=%b k=%b a=%h want %b,%b,%h",
                 i, stall4, ack4, mem_addr4, e_stall, e_ack, e_addr);
      end
      if (i == 5) begin
        total++;
        if (hrd4 !== 16'h1234) begin
          bad++; $display("FAIL contend_rd got %h want 1234", hrd4);
        end
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_limit0();
    @(negedge clk);
    @(negedge clk);
    cpu_req = 1; cpu_we = 1;
    cpu_addr = 16'h0040; cpu_wdata = 16'h7777;
    host_req = 1; host_we = 0; host_addr = 16'h0020;
    #2;
    total++;
    if ({stall0, mem_we0, mem_addr0} !== {1'b1, 1'b0, 16'h0020}) begin
      bad++;
      $display("FAIL lim0_grant got s=%b we=%b a=%h want 1,0,0020",
               stall0, mem_we0, mem_addr0);
    end
    @(negedge clk);
    host_req = 0;
    #2;
    total++;
    if ({ack0, stall0, mem_we0} !== 3'b101) begin
      bad++;
      $display("FAIL lim0_ack got k=%b s=%b we=%b want 1,0,1",
               ack0, stall0, mem_we0);
    end
    total++;
    if (hrd0 !== 16'h1234) begin
      bad++; $display("FAIL lim0_rd got %h want 1234", hrd0);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    cpu_req = 1; cpu_we = 1;
    cpu_addr = 16'h0030; cpu_wdata = 16'haaaa;
    @(negedge clk);
    idle_inputs();
    host_req = 1; host_we = 1;
    host_addr = 16'h0030; host_wdata = 16'h5555;
    #2;
    total++;
    if (mem_we4 !== 1'b1) begin
      bad++; $display("FAIL mid_grant got %b want 1", mem_we4);
    end
    #1 rst_n = 0;
    #1;
    total++;
    if (mem_we4 !== 1'b0) begin
      bad++; $display("FAIL mid_we got %b want 0", mem_we4);
    end
    @(negedge clk);
    rst_n = 1; host_req = 0;
    #2;
    total++;
    if ({ack4, hrd4} !== {1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL mid_ack got k=%b d=%h want 0,0000", ack4, hrd4);
    end
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0030;
    #2;
    total++;
    if (cpu_rdata4 !== 16'haaaa) begin
      bad++; $display("FAIL mid_keep got %h want aaaa", cpu_rdata4);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  // Model: host wins when idle-eligible and (core absent or it has
  // already lost lim times); an ack follows each host win.
  task automatic test_random(input int lim, input int ncyc);
    logic [15:0] em [0:255];
    int          losses;
    bit          ackc, pstall, helig, hwin, cg, e_we;
    logic [15:0] ack_d, e_addr;
    logic        o_stall, o_we, o_ack;
    logic [15:0] o_addr, o_hrd, o_crd;
    for (int i = 0; i < 256; i++) em[i] = '0;
    losses = 0; ackc = 0; pstall = 0; ack_d = '0;
    @(negedge clk);
    rst_n = 0; mem_clr = 1;
    idle_inputs();
    @(negedge clk);
    rst_n = 1; mem_clr = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (!pstall) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 16'($urandom_range(0, 255));
        cpu_wdata = 16'($urandom);
      end
      if (ackc || !host_req) begin
        host_req   = (ackc || !host_req) && ($urandom_range(0, 1) == 1);
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = 16'($urandom_range(0, 255));
        host_wdata = 16'($urandom);
      end
      #2;
      helig  = host_req && !ackc;
      hwin   = helig && (!cpu_req || losses >= lim);
      cg     = cpu_req && !hwin;
      e_we   = hwin ? host_we : (cg && cpu_we);
      e_addr = hwin ? host_addr : cpu_addr;
      o_stall = (lim == 0) ? stall0 : stall4;
      o_we    = (lim == 0) ? mem_we0 : mem_we4;
      o_ack   = (lim == 0) ? ack0 : ack4;
      o_addr  = (lim == 0) ? mem_addr0 : mem_addr4;
      o_hrd   = (lim == 0) ? hrd0 : hrd4;
      o_crd   = (lim == 0) ? cpu_rdata0 : cpu_rdata4;
      total++;
      if ({o_stall, o_we, o_addr} !== {cpu_req && !cg, e_we, e_addr}) begin
        bad++;
        $display("FAIL rnd%0d_c%0d bus got s=%b we=%b a=%h want %b,%b,%h",
                 lim, c, o_stall, o_we, o_addr,
                 cpu_req && !cg, e_we, e_addr);
      end
      total++;
      if ({o_ack, o_hrd} !== {ackc, ack_d}) begin
        bad++;
        $display("FAIL rnd%0d_c%0d host got k=%b d=%h want %b,%h",
                 lim, c, o_ack, o_hrd, ackc, ack_d);
      end
      if (cg && !cpu_we) begin
        total++;
        if (o_crd !== em[cpu_addr[7:0]]) begin
          bad++;
          $display("FAIL rnd%0d_c%0d cpu_rd got %h want %h",
                   lim, c, o_crd, em[cpu_addr[7:0]]);
        end
      end
      @(posedge clk);
      if (hwin) begin
        ack_d = em[host_addr[7:0]];
        if (host_we) em[host_addr[7:0]] = host_wdata;
      end else if (cg && cpu_we) begin
        em[cpu_addr[7:0]] = cpu_wdata;
      end
      if (!host_req || hwin) losses = 0;
      else if (helig) losses++;
      ackc   = hwin;
      pstall = cpu_req && !cg;
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      total++;
      o_crd = (lim == 0) ? mem0[i] : mem4[i];
      if (o_crd !== em[i]) begin
        bad++;
        $display("FAIL rnd%0d_mem[%0d] got %h want %h",
                 lim, i, o_crd, em[i]);
      end
    end
  endtask

  initial begin
    rst_n = 0;
    mem_clr = 0;
    idle_inputs();
    test_reset();
    test_core_only();
    test_host_only();
    test_contention();
    test_limit0();
    test_mid_reset();
    test_random(4, 600);
    test_random(0, 400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the CPU's single-port data memory between the core's load/store path and an external host port used for debug and program/data loading. The core keeps priority. A starvation counter forces a host grant after a bounded wait. The core sees a combinational stall, and the host sees a registered one-cycle acknowledge. The block sits in `cpu_top` between the ALU-address/store-data path and `data_memory`.

## Interface
- `ADDR_W`, default 16: address width.
- `DATA_W`, default 16: data width.
- `STARVE_LIM`, default 4: maximum number of consecutive cycles a pending host request may lose to the core. 0 gives the host absolute priority.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low. The block is in reset while 0.
- `cpu_req`, input, 1: core access this cycle; `MemWrite | MemToReg`.
- `cpu_we`, input, 1: core write.
- `cpu_addr`, input, ADDR_W: core address (ALU result).
- `cpu_wdata`, input, DATA_W: core store data.
- `cpu_rdata`, output, DATA_W: load data, combinational pass-through of `mem_rdata`.
- `cpu_stall`, output, 1: core access not granted this cycle. Gates `pc_write` and `reg_we`.
- `host_req`, input, 1: host access request. Held with stable `host_we`/`host_addr`/`host_wdata` until `host_ack`.
- `host_we`, input, 1: host write.
- `host_addr`, input, ADDR_W: host address.
- `host_wdata`, input, DATA_W: host write data.
- `host_rdata`, output, DATA_W: registered read data, valid while `host_ack`=1.
- `host_ack`, output, 1: one-cycle pulse marking completion of a host access.
- `mem_we`, output, 1: to `data_memory.we`.
- `mem_addr`, output, ADDR_W: to `data_memory.addr`.
- `mem_wdata`, output, DATA_W: to `data_memory.wdata`.
- `mem_rdata`, input, DATA_W: from `data_memory.rdata` (combinational read).

## Operation
- **Host FSM states:** `H_IDLE` and `H_ACK`. Transitions:
  - `H_IDLE` to `H_ACK` on a host grant.
  - `H_ACK` to `H_IDLE` unconditionally after one cycle.
- **Host eligibility:** the host is eligible only in `H_IDLE` with `host_req`=1.
- **Grant, evaluated combinationally per cycle:**
  - The host is granted if it is eligible and any of these hold: `cpu_req`=0, `wait_cnt`==`STARVE_LIM`, or `STARVE_LIM`==0.
  - Otherwise the core is granted if `cpu_req`=1.
  - Otherwise nothing is granted.
- **Memory mux:**
  - On a host grant, `mem_*` are driven from `host_*`.
  - In all other cycles, `mem_addr`/`mem_wdata` are driven from `cpu_*`.
  - `mem_we` = (granted requester's we) AND granted.
- **Core stall:** `cpu_stall` = `cpu_req` & ~core_grant. While stalled, the core holds its instruction, so the request repeats next cycle unchanged.
- **Host completion:** on the edge ending a host-grant cycle, `host_rdata` <= `mem_rdata` (read or write; for a write it is the pre-write content), `host_ack` <= 1.
- **`wait_cnt`**, width clog2(`STARVE_LIM`+1), min 1:
  - Increments, saturating at `STARVE_LIM`, on each cycle the host is eligible but not granted.
  - Clears on a host grant or when `host_req`=0.
- **Turnaround:** the host is never granted in `H_ACK`. A host that keeps `host_req` high through the ack cycle is treated as issuing a new request, eligible next cycle.

## Timing
- **Reset values:** `host_ack`=0, `host_rdata`=0, FSM=`H_IDLE`, `wait_cnt`=0.
- **Outputs during reset:** `mem_we` is forced 0 and `cpu_stall` is forced 0 while `reset`=0, regardless of the requests.
- **Core latency:** 0 cycles when granted. The write lands on the grant-cycle edge, and read data is valid in the grant cycle.
- **Host latency:** grant in cycle t, `host_ack`/`host_rdata` in cycle t+1. Minimum host request spacing is 2 cycles.
- **Worst-case core stall:** 1 cycle per host access, since the core always wins the ack cycle. Worst-case host wait is `STARVE_LIM` cycles.
- **Reset asserted mid-access:** the FSM returns to `H_IDLE` immediately and no ack is produced. If reset drops before the grant-cycle edge, no memory write occurs. The host must reissue.
- **Simultaneous requests** with `wait_cnt`<`STARVE_LIM`: the core wins, and `wait_cnt` increments.

## Structure
- **Shared defines header:** the host FSM state encodings `H_IDLE`=1'b0 and `H_ACK`=1'b1, and the default `STARVE_LIM`.
- **Sub-module:** one small sub-module, `dmem_starve_counter`, containing the saturating counter and the `at_limit` flag. The grant logic and muxes stay inline.
- **`cpu_top` integration:**
  - `pc_write` = ~Halt & ~`cpu_stall`.
  - `reg_we` and `NZP_we` are qualified with ~`cpu_stall`.

## Test plan
- **Reset:** hold `reset`=0 with `cpu_req`=`host_req`=1 and both `we`=1. Required: `mem_we`=0, `cpu_stall`=0, `host_ack`=0, `host_rdata`=0x0000.
- **Core only:** core writes 0x0010=0xBEEF. Required: `mem_we`=1 in the same cycle, `cpu_stall`=0. The next-cycle core read of 0x0010 gives `cpu_rdata`=0xBEEF.
- **Host only:** host writes 0x0020=0x1234; `host_ack` pulses exactly one cycle later. A host read of 0x0020 then gives `host_ack`=1 with `host_rdata`=0x1234, and no grant occurs in the ack cycle.
- **Contention, `STARVE_LIM`=4:**
  - Stimulus: continuous `cpu_req` with `host_req` held.
  - Cycles 0–3: core granted, `wait_cnt` 1..4.
  - Cycle 4: host granted, `cpu_stall`=1.
  - Cycle 5: `host_ack`=1, core granted.
- **`STARVE_LIM`=0:** simultaneous requests give a host grant and `cpu_stall`=1 in the first cycle, and the core is granted in the ack cycle.
- **Reset mid-access:** drive `reset` to 0 during a host write grant cycle to 0x0030=0x5555. Required: no ack, and 0x0030 retains its prior value.
